// File: rtl/ks_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : ks_pipe_adder
// Brief    : Pipelined Kogge-Stone adder/subtractor, one prefix level per stage,
//            valid/ready handshake with whole-pipe stall, cout/ovf/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module ks_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int LL    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_msb = WIDTH - 1;

    if (WIDTH < 2 || (1 << LL) < WIDTH) begin : g_param_chk
        $error("ks_pipe_adder: need WIDTH >= 2 and 2**LL >= WIDTH");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_beff;
    logic [WIDTH-1:0] w_p0s;
    logic [WIDTH-1:0] w_g0;
    logic             w_c0;
    logic [WIDTH-1:0] w_gn [1:LL];
    logic [WIDTH-1:0] w_pn [1:LL];
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [LL:0]      r_v;
    logic [LL:0]      r_c0;
    logic [LL:0]      r_amsb;
    logic [LL:0]      r_bmsb;
    logic [WIDTH-1:0] r_g  [0:LL];
    logic [WIDTH-1:0] r_p  [0:LL-1];
    logic [WIDTH-1:0] r_p0 [0:LL];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    // Carry-in enters as a generate at bit -1, folded into G[0].
    always_comb begin
        w_beff   = sub ? ~b : b;
        w_c0     = sub | cin;
        w_p0s    = a ^ w_beff;
        w_g0     = a & w_beff;
        w_g0[0]  = w_g0[0] | (w_p0s[0] & w_c0);
    end

    always_comb begin
        for (int i = 1; i <= LL; i++) begin
            w_gn[i] = r_g[i-1];
            w_pn[i] = (i < LL) ? r_p[i-1] : '0;
            for (int j = (1 << (i-1)); j < WIDTH; j++) begin
                w_gn[i][j] = r_g[i-1][j] | (r_p[i-1][j] & r_g[i-1][j - (1 << (i-1))]);
            end
        end
        for (int i = 1; i < LL; i++) begin
            for (int j = (1 << (i-1)); j < WIDTH; j++) begin
                w_pn[i][j] = r_p[i-1][j] & r_p[i-1][j - (1 << (i-1))];
            end
        end
    end

    always_comb begin
        w_sum = r_p0[LL] ^ {r_g[LL][WIDTH-2:0], r_c0[LL]};
        w_ovf = (r_amsb[LL] == r_bmsb[LL]) && (w_sum[c_msb] != r_amsb[LL]);
    end

    // Every register, including empty stages, moves only on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v         <= '0;
            r_c0        <= '0;
            r_amsb      <= '0;
            r_bmsb      <= '0;
            for (int i = 0; i <= LL; i++) begin
                r_g[i]  <= '0;
                r_p0[i] <= '0;
            end
            for (int i = 0; i < LL; i++) begin
                r_p[i]  <= '0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_advance) begin
            r_v     <= {r_v[LL-1:0], in_valid};
            r_c0    <= {r_c0[LL-1:0], w_c0};
            r_amsb  <= {r_amsb[LL-1:0], a[c_msb]};
            r_bmsb  <= {r_bmsb[LL-1:0], w_beff[c_msb]};
            r_g[0]  <= w_g0;
            r_p[0]  <= w_p0s;
            r_p0[0] <= w_p0s;
            for (int i = 1; i <= LL; i++) begin
                r_g[i]  <= w_gn[i];
                r_p0[i] <= r_p0[i-1];
            end
            for (int i = 1; i < LL; i++) begin
                r_p[i]  <= w_pn[i];
            end
            r_out_valid <= r_v[LL];
            r_sum       <= w_sum;
            r_cout      <= r_g[LL][c_msb];
            r_ovf       <= w_ovf;
            r_zero      <= (w_sum == '0);
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_ks_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ks_pipe_adder
// Brief    : Directed self-checking bench for ks_pipe_adder at 32/5 and 16/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ks_pipe_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv32 = 1'b0, ir32, ci32 = 1'b0, su32 = 1'b0, ov32, or32 = 1'b1;
    logic        co32, of32, z32;
    logic [31:0] a32 = '0, b32 = '0, s32;

    logic        iv16 = 1'b0, ir16, ci16 = 1'b0, su16 = 1'b0, ov16, or16 = 1'b1;
    logic        co16, of16, z16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ks_pipe_adder #(.WIDTH(32), .LL(5)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .cin(ci32), .sub(su32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(of32), .zero(z32)
    );

    ks_pipe_adder #(.WIDTH(16), .LL(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(ci16), .sub(su16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16), .zero(z16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic iv, input logic [31:0] av, input logic [31:0] bv,
                         input logic civ, input logic suv);
        if (sel == 0) begin
            iv32 = iv; a32 = av; b32 = bv; ci32 = civ; su32 = suv;
        end else begin
            iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; ci16 = civ; su16 = suv;
        end
    endtask

    task automatic smp(input int sel, output logic ov, output logic [31:0] s, output logic co,
                       output logic of, output logic z, output logic ir);
        if (sel == 0) begin
            ov = ov32; s = s32; co = co32; of = of32; z = z32; ir = ir32;
        end else begin
            ov = ov16; s = {16'h0, s16}; co = co16; of = of16; z = z16; ir = ir16;
        end
    endtask

    task automatic one(input int sel, input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic civ, input logic suv, input logic [31:0] es,
                       input logic eco, input logic eof, input logic ez);
        int          lat;
        int          exp_lat;
        logic        ov, co, of, z, ir;
        logic [31:0] s;
        exp_lat = (sel == 0) ? 6 : 5;
        @(negedge clk);
        drive(sel, 1'b1, av, bv, civ, suv);
        #1 smp(sel, ov, s, co, of, z, ir);
        chk({tag, "_rdy"}, 64'(ir), 64'd1);
        @(posedge clk);
        #1 drive(sel, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        lat = 0;
        ov  = 1'b0;
        while (!ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            smp(sel, ov, s, co, of, z, ir);
        end
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_sum"},  64'(s),   64'(es));
        chk({tag, "_cout"}, 64'(co),  64'(eco));
        chk({tag, "_ovf"},  64'(of),  64'(eof));
        chk({tag, "_zero"}, 64'(z),   64'(ez));
    endtask

    initial begin
        logic        ov, co, of, z, ir, acc;
        logic [31:0] s;
        int          got, gaps, idx, stall_n, cyc, extra;
        bit          seen;

        // reset state
        #12;
        chk("rst_ov32",  64'(ov32), 64'd0);
        chk("rst_sum32", 64'(s32),  64'd0);
        chk("rst_flg32", 64'({co32, of32, z32}), 64'd0);
        chk("rst_ov16",  64'(ov16), 64'd0);
        chk("rst_sum16", 64'(s16),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rdy32", 64'(ir32), 64'd1);
        chk("rst_rdy16", 64'(ir16), 64'd1);

        // directed vectors, WIDTH=32
        one(0, "add",     32'h000001E0, 32'h0000000F, 1'b0, 1'b0, 32'h000001EF, 1'b0, 1'b0, 1'b0);
        one(0, "addc",    32'h000001E0, 32'h0000000F, 1'b1, 1'b0, 32'h000001F0, 1'b0, 1'b0, 1'b0);
        one(0, "wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        one(0, "sovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        one(0, "sub57",   32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        one(0, "sub75",   32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        one(0, "subovf",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        one(0, "sub55",   32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

        // directed vectors, WIDTH=16
        one(1, "h_add",    32'h01E0, 32'h000F, 1'b0, 1'b0, 32'h01EF, 1'b0, 1'b0, 1'b0);
        one(1, "h_addc",   32'h01E0, 32'h000F, 1'b1, 1'b0, 32'h01F0, 1'b0, 1'b0, 1'b0);
        one(1, "h_wrap",   32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
        one(1, "h_sovf",   32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
        one(1, "h_sub57",  32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
        one(1, "h_sub75",  32'h0007, 32'h0005, 1'b1, 1'b1, 32'h0002, 1'b1, 1'b0, 1'b0);
        one(1, "h_subovf", 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);

        // throughput: 8 back-to-back beats
        got = 0; gaps = 0; seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 8) drive(0, 1'b1, 32'(c + 1), 32'(c + 1), 1'b0, 1'b0);
            else       drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            @(posedge clk);
            #1 smp(0, ov, s, co, of, z, ir);
            if (ov) begin
                got++;
                seen = 1'b1;
                chk("tp_sum", 64'(s), 64'(2 * got));
            end else if (seen && got < 8) begin
                gaps++;
            end
        end
        chk("tp_cnt", 64'(got), 64'd8);
        chk("tp_gap", 64'(gaps), 64'd0);

        // backpressure: 4-cycle stall once two results have been taken
        got = 0; idx = 0; stall_n = 0; cyc = 0;
        while (got < 8 && cyc < 80) begin
            cyc++;
            @(negedge clk);
            or32 = !(got == 2 && stall_n < 4);
            if (idx < 8) drive(0, 1'b1, 32'(idx + 1), 32'd100, 1'b0, 1'b0);
            else         drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            #1 smp(0, ov, s, co, of, z, ir);
            acc = iv32 && ir;
            if (ov && !or32) begin
                stall_n++;
                chk("bp_rdy",  64'(ir), 64'd0);
                chk("bp_hold", 64'(s),  64'(100 + got + 1));
                chk("bp_flg",  64'({co, of, z}), 64'd0);
            end else if (ov) begin
                got++;
                chk("bp_sum", 64'(s), 64'(100 + got));
            end
            @(posedge clk);
            if (acc) idx++;
        end
        or32 = 1'b1;
        chk("bp_cnt",   64'(got),     64'd8);
        chk("bp_stall", 64'(stall_n), 64'd4);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            if (ov32) extra++;
        end
        chk("bp_dup", 64'(extra), 64'd0);

        // asynchronous reset with beats in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'(10 + c), 32'd20, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc = 0;
        while (!ov32 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("rf_first", 64'(s32), 64'd30);
        #2 rst = 1'b1;
        #1;
        chk("rf_ov",  64'(ov32), 64'd0);
        chk("rf_sum", 64'(s32),  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ov32) extra++;
        end
        chk("rf_stale", 64'(extra), 64'd0);
        one(0, "rf_new", 32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
